// File: rtl/aho_event_monitor_if.sv
// Signal bundle between the aho detector side and the event monitor:
// the AHO level and clear request in, the LED and statistics out.
interface aho_event_monitor_if #(
  parameter int RUN_W = 8
);
  logic             AHO;
  logic             CLR;
  logic             LED;
  logic [15:0]      EVT_BCD;
  logic             OVF;
  logic [RUN_W-1:0] RUN_LEN;
  logic [RUN_W-1:0] MAX_RUN;

  modport master (
    output AHO, CLR,
    input  LED, EVT_BCD, OVF, RUN_LEN, MAX_RUN
  );

  modport slave (
    input  AHO, CLR,
    output LED, EVT_BCD, OVF, RUN_LEN, MAX_RUN
  );
endinterface

// File: rtl/aho_event_monitor.sv
// Event monitor for the aho detector output: saturating BCD rise counter with
// sticky overflow, stretched LED indication and current/longest run tracking.
module aho_event_monitor #(
  parameter int STRETCH = 4,
  parameter int RUN_W   = 8
) (
  input logic                CLK,
  input logic                RST,
  aho_event_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0]       HOLD_INIT = 8'(STRETCH - 1);
  localparam logic [RUN_W-1:0] RUN_SAT   = '1;

  logic             aho_q;
  logic             rise;
  logic [15:0]      evt_q;
  logic [15:0]      evt_inc;
  logic             carry;
  logic             ovf_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_nx;
  logic [RUN_W-1:0] max_q;
  state_t           state_q;
  state_t           state_d;
  logic [7:0]       hold_q;
  logic [7:0]       hold_d;
  logic             led_q;

  assign rise = mon.AHO & ~aho_q;

  // Per-digit BCD ripple: a 9 rolls to 0 and passes the carry upward.
  always_comb begin
    evt_inc = evt_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (evt_q[4*i +: 4] == 4'd9) begin
          evt_inc[4*i +: 4] = 4'd0;
        end else begin
          evt_inc[4*i +: 4] = evt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    if (!mon.AHO) begin
      run_nx = '0;
    end else if (run_q == RUN_SAT) begin
      run_nx = run_q;
    end else begin
      run_nx = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aho_q <= 1'b0;
    end else begin
      aho_q <= mon.AHO;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_q <= '0;
      ovf_q <= 1'b0;
      run_q <= '0;
      max_q <= '0;
    end else if (mon.CLR) begin
      evt_q <= '0;
      ovf_q <= 1'b0;
      run_q <= '0;
      max_q <= '0;
    end else begin
      if (rise) begin
        if (evt_q == 16'h9999) begin
          ovf_q <= 1'b1;
        end else begin
          evt_q <= evt_inc;
        end
      end
      run_q <= run_nx;
      if (run_nx > max_q) begin
        max_q <= run_nx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (mon.AHO) state_d = ON;
      end
      ON: begin
        if (!mon.AHO) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (mon.AHO) begin
          state_d = ON;
        end else if (hold_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LED is registered from the next-state decode so it matches the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      led_q   <= (state_d != IDLE);
    end
  end

  assign mon.LED     = led_q;
  assign mon.EVT_BCD = evt_q;
  assign mon.OVF     = ovf_q;
  assign mon.RUN_LEN = run_q;
  assign mon.MAX_RUN = max_q;

endmodule

// File: tb/tb_aho_event_monitor.sv
// Scoreboard bench for aho_event_monitor: stimulus pushes expected outputs per
// cycle, an independent monitor pops and compares after each clock or reset.
module tb_aho_event_monitor;

  localparam int STRETCH = 4;
  localparam int RUN_W   = 8;
  localparam int RUN_SAT = 255;

  typedef struct {
    bit         chk;
    logic [15:0] evt;
    logic        ovf;
    logic        led;
    logic [7:0]  run;
    logic [7:0]  max;
  } exp_t;

  logic CLK;
  logic RST;

  aho_event_monitor_if #(.RUN_W(RUN_W)) bus ();

  aho_event_monitor #(
    .STRETCH(STRETCH),
    .RUN_W  (RUN_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .mon(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: plain integers, LED from "edges since AHO was last high".
  int m_evt, m_run, m_max, m_zeros;
  bit m_ovf, m_prev;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_evt = 0; m_run = 0; m_max = 0; m_ovf = 0; m_prev = 0; m_zeros = 1000;
  endtask

  task automatic model_step(input bit aho, input bit clr, output exp_t e);
    bit rise;
    rise = aho && !m_prev;
    if (clr) begin
      m_evt = 0; m_ovf = 0; m_run = 0; m_max = 0;
    end else begin
      if (rise) begin
        if (m_evt == 9999) m_ovf = 1;
        else m_evt = m_evt + 1;
      end
      m_run = aho ? ((m_run + 1 > RUN_SAT) ? RUN_SAT : m_run + 1) : 0;
      if (m_run > m_max) m_max = m_run;
    end
    m_prev  = aho;
    m_zeros = aho ? 0 : ((m_zeros < 1000) ? m_zeros + 1 : m_zeros);
    e.chk = 1;
    e.evt = to_bcd(m_evt);
    e.ovf = m_ovf;
    e.led = (m_zeros <= STRETCH);
    e.run = 8'(m_run);
    e.max = 8'(m_max);
  endtask

  task automatic step(input bit aho, input bit clr);
    exp_t e;
    @(negedge CLK);
    bus.AHO = aho;
    bus.CLR = clr;
    model_step(aho, clr, e);
    sb.push_back(e);
  endtask

  task automatic step_hand(input bit aho, input bit clr, input logic [15:0] evt,
                           input logic ovf, input logic led, input logic [7:0] run,
                           input logic [7:0] max);
    exp_t e, unused;
    @(negedge CLK);
    bus.AHO = aho;
    bus.CLR = clr;
    model_step(aho, clr, unused);
    e.chk = 1; e.evt = evt; e.ovf = ovf; e.led = led; e.run = run; e.max = max;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge (or reset assertion) while stimulus runs.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or posedge RST);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("evt_bcd", bus.EVT_BCD, e.evt);
          cmp("ovf", 16'(bus.OVF), 16'(e.ovf));
          cmp("led", 16'(bus.LED), 16'(e.led));
          cmp("run_len", 16'(bus.RUN_LEN), 16'(e.run));
          cmp("max_run", 16'(bus.MAX_RUN), 16'(e.max));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z;
    RST = 1'b1;
    bus.AHO = 1'b0;
    bus.CLR = 1'b0;
    model_reset();

    // Reset state while RST is held.
    repeat (2) @(negedge CLK);
    z.chk = 1; z.evt = '0; z.ovf = 0; z.led = 0; z.run = '0; z.max = '0;
    sb.push_back(z);
    @(negedge CLK);
    RST = 1'b0;

    // Three-cycle pulse: LED high for 3 + STRETCH edges.
    step_hand(1, 0, 16'h0001, 0, 1, 8'd1, 8'd1);
    step_hand(1, 0, 16'h0001, 0, 1, 8'd2, 8'd2);
    step_hand(1, 0, 16'h0001, 0, 1, 8'd3, 8'd3);
    step_hand(0, 0, 16'h0001, 0, 1, 8'd0, 8'd3);
    step_hand(0, 0, 16'h0001, 0, 1, 8'd0, 8'd3);
    step_hand(0, 0, 16'h0001, 0, 1, 8'd0, 8'd3);
    step_hand(0, 0, 16'h0001, 0, 1, 8'd0, 8'd3);
    step_hand(0, 0, 16'h0001, 0, 0, 8'd0, 8'd3);
    step_hand(0, 0, 16'h0001, 0, 0, 8'd0, 8'd3);

    // 1000 single-cycle pulses: 0x0999 -> 0x1000 carry, LED continuously high.
    step_hand(0, 1, 16'h0000, 0, 0, 8'd0, 8'd0);
    for (int i = 0; i < 999; i++) begin
      step(1, 0);
      step(0, 0);
    end
    step_hand(1, 0, 16'h1000, 0, 1, 8'd1, 8'd1);
    step_hand(0, 0, 16'h1000, 0, 1, 8'd0, 8'd1);

    // Preload to 9999, then two extra pulses saturate and set OVF.
    for (int i = 0; i < 8999; i++) begin
      step(1, 0);
      step(0, 0);
    end
    step_hand(1, 0, 16'h9999, 1, 1, 8'd1, 8'd1);
    step_hand(0, 0, 16'h9999, 1, 1, 8'd0, 8'd1);
    step_hand(1, 0, 16'h9999, 1, 1, 8'd1, 8'd1);
    step_hand(0, 1, 16'h0000, 0, 1, 8'd0, 8'd0);
    step(0, 0);

    // Long run saturates RUN_LEN and MAX_RUN.
    for (int i = 0; i < 300; i++) step(1, 0);
    step_hand(0, 0, 16'h0001, 0, 1, 8'd0, 8'd255);
    for (int i = 0; i < 8; i++) step(0, 0);

    // CLR on the rising edge wins over the count; LED still responds.
    step_hand(1, 1, 16'h0000, 0, 1, 8'd0, 8'd0);
    step_hand(1, 0, 16'h0000, 0, 1, 8'd1, 8'd1);
    step(0, 0);
    for (int i = 0; i < 8; i++) step(0, 0);

    // Asynchronous reset during HOLD with hold_cnt == 2.
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    @(negedge CLK);
    sb.push_back(z);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    model_reset();
    step_hand(0, 0, 16'h0000, 0, 0, 8'd0, 8'd0);
    step_hand(1, 0, 16'h0001, 0, 1, 8'd1, 8'd1);
    step_hand(0, 0, 16'h0001, 0, 1, 8'd0, 8'd1);

    repeat (3) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aho_event_monitor.md
Name: aho_event_monitor

Overview:
- Sits directly downstream of the aho detector and consumes its AHO output.
- Counts AHO rising edges as a 4-digit BCD event count, saturating at 9999 with a sticky overflow flag.
- Stretches AHO into a visible LED pulse through a 3-state FSM.
- Tracks the current and the longest run of consecutive AHO-high cycles.

Parameters:
- STRETCH, 4: LED hold cycles after AHO falls; legal range 1..255.
- RUN_W, 8: width of the run-length counters.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- AHO  in  1  level from the aho detector; synchronous to CLK.
- CLR  in  1  synchronous clear of the statistics.
- LED  out  1  stretched AHO indication; registered.
- EVT_BCD  out  16  event count, 4 BCD digits; [15:12] is thousands, [3:0] is units.
- OVF  out  1  sticky: an event occurred while EVT_BCD was 9999.
- RUN_LEN  out  RUN_W  current consecutive AHO-high cycle count.
- MAX_RUN  out  RUN_W  longest run since reset or CLR.

Behaviour:
- Reset (RST=1, asynchronous): LED=0, EVT_BCD=0x0000, OVF=0, RUN_LEN=0, MAX_RUN=0, FSM=IDLE, aho_q=0, hold_cnt=0. The first edge after release with AHO=1 counts as a rise. RST asserted mid-operation aborts any count or hold immediately.
- Edge detect:
  - aho_q <= AHO every cycle.
  - rise = AHO & ~aho_q, combinational.
- Event counter:
  - On an edge with rise=1, EVT_BCD increments. The new value is visible right after that edge (latency 0 from the sampled edge).
  - BCD ripple per digit: a digit at 9 goes to 0 and carries into the next digit. Example: 0x0999 goes to 0x1000.
  - At 0x9999, a rise leaves EVT_BCD unchanged and sets OVF=1.
  - OVF clears only on RST or CLR.
- Run counters:
  - Edge with AHO=1: RUN_LEN <= RUN_LEN+1, saturating at 2^RUN_W-1.
  - Edge with AHO=0: RUN_LEN <= 0.
  - MAX_RUN <= max(MAX_RUN, next RUN_LEN), so it tracks the run live, including while RUN_LEN is saturated.
- CLR (synchronous, checked at the edge):
  - Sets EVT_BCD, OVF, RUN_LEN and MAX_RUN to 0.
  - CLR has priority over a simultaneous rise or AHO=1: that edge is not counted and RUN_LEN stays 0.
  - Does not affect aho_q, the FSM, hold_cnt or LED.
- LED FSM (LED=1 in ON and HOLD, 0 in IDLE; LED is the registered state decode):
  - IDLE: AHO=1 -> ON.
  - ON: AHO=0 -> HOLD, with hold_cnt <= STRETCH-1.
  - HOLD, AHO=1: -> ON (retrigger; hold_cnt is ignored).
  - HOLD, AHO=0, hold_cnt==0: -> IDLE.
  - HOLD, AHO=0, hold_cnt!=0: hold_cnt decrements.
  - Net effect: LED rises one edge after AHO rises, and stays high for the AHO-high cycles plus STRETCH cycles.
  - A re-pulse during HOLD merges into one continuous LED pulse.
- Arithmetic: all counters are unsigned. No wrap anywhere: the BCD count saturates, and RUN_LEN/MAX_RUN saturate.

Test Plan:
- Reset, then AHO=1 for 3 cycles and 0 afterwards, STRETCH=4:
  - EVT_BCD=0x0001.
  - RUN_LEN goes 1,2,3, then 0.
  - MAX_RUN=3.
  - LED high for exactly 7 cycles, starting one edge after AHO rose.
- 1000 single-cycle AHO pulses spaced 2 cycles apart: EVT_BCD=0x1000 with the intermediate 0x0999->0x1000 carry checked. LED stays continuously high, since gaps are shorter than STRETCH.
- Preload to 9999 with 9999 pulses, then 2 more pulses: EVT_BCD holds 0x9999, OVF=1 from the first extra pulse. Then CLR=1 for one cycle: EVT_BCD=0, OVF=0, MAX_RUN=0.
- AHO held high 300 cycles, RUN_W=8: RUN_LEN and MAX_RUN saturate at 255. On AHO fall, RUN_LEN=0 and MAX_RUN stays 255.
- CLR asserted on the same edge as an AHO rise: EVT_BCD stays 0 and RUN_LEN stays 0. LED still goes high, since the FSM is unaffected.
- RST pulsed while LED is in HOLD with hold_cnt=2: LED=0, FSM=IDLE and all counts 0 immediately, before the next clock edge.
